// File: rtl/common_pkg.sv
// Shared parameters and helpers for the credit-based pi switch blocks.
package common_pkg;

  localparam int DEFAULT_VC_W          = 1;
  localparam int DEFAULT_VC_FIFO_DEPTH = 4;

  // Counter width able to hold depth-1 credits.
  function automatic int cred_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first request found
// when searching upward from ptr, wrapping at N.
module rr_arbiter #(
  parameter  int N  = 3,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  logic found;
  int   idx;

  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/credit_out_scheduler.sv
// Output-port scheduler: round-robin grant among requesters whose target VC
// has a downstream credit, with per-VC credit counters and registered mux select.
module credit_out_scheduler
  import common_pkg::*;
#(
  parameter  int NUM_REQ       = 3,
  parameter  int VC_W          = DEFAULT_VC_W,
  parameter  int VC_FIFO_DEPTH = DEFAULT_VC_FIFO_DEPTH,
  localparam int NVC           = 2 ** VC_W,
  localparam int CRED_W        = cred_width(VC_FIFO_DEPTH),
  localparam int SEL_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ*VC_W-1:0] req_vc,
  output logic [NUM_REQ-1:0]      gnt,
  input  logic                    cred_ret,
  input  logic [VC_W-1:0]         cred_ret_vc,
  output logic                    out_valid,
  output logic [SEL_W-1:0]        out_sel,
  output logic [VC_W-1:0]         out_vc,
  output logic [NVC-1:0]          cred_avail,
  output logic                    cred_err
);

  localparam logic [CRED_W-1:0] CMAX = CRED_W'(VC_FIFO_DEPTH - 1);

  logic [CRED_W-1:0]  cred [NVC];
  logic [SEL_W-1:0]   ptr;
  logic [NUM_REQ-1:0] elig;
  logic [SEL_W-1:0]   gnt_idx;
  logic [VC_W-1:0]    gnt_vc;
  logic               gnt_any;
  logic [NVC-1:0]     cons_v;
  logic [NVC-1:0]     ret_v;

  // Eligibility is masked by reset so gnt is forced low while rst is asserted.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_REQ; i++)
      elig[i] = rst && req[i] && (cred[req_vc[i*VC_W +: VC_W]] != '0);
  end

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req (elig),
    .ptr (ptr),
    .gnt (gnt)
  );

  always_comb begin
    gnt_idx = '0;
    gnt_vc  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        gnt_idx = SEL_W'(i);
        gnt_vc  = req_vc[i*VC_W +: VC_W];
      end
    end
  end

  assign gnt_any = |gnt;

  always_comb begin
    cons_v     = '0;
    ret_v      = '0;
    cred_avail = '0;
    for (int v = 0; v < NVC; v++) begin
      cons_v[v]     = gnt_any && (gnt_vc == VC_W'(v));
      ret_v[v]      = cred_ret && (cred_ret_vc == VC_W'(v));
      cred_avail[v] = (cred[v] != '0);
    end
  end

  // NOTE: the counter array is small and must restart full, so every entry is
  // reset explicitly; a large RAM-backed array would not be reset this way.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int v = 0; v < NVC; v++) cred[v] <= CMAX;
      cred_err <= 1'b0;
    end else begin
      for (int v = 0; v < NVC; v++) begin
        if (ret_v[v] && !cons_v[v]) begin
          // A return into a full counter is a protocol error; saturate and flag.
          if (cred[v] == CMAX) cred_err <= 1'b1;
          else                 cred[v]  <= cred[v] + 1'b1;
        end else if (cons_v[v] && !ret_v[v]) begin
          cred[v] <= cred[v] - 1'b1;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr       <= '0;
      out_valid <= 1'b0;
      out_sel   <= '0;
      out_vc    <= '0;
    end else begin
      out_valid <= gnt_any;
      if (gnt_any) begin
        ptr     <= (gnt_idx == SEL_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        out_sel <= gnt_idx;
        out_vc  <= gnt_vc;
      end
    end
  end

endmodule

// File: tb/tb_credit_out_scheduler.sv
// Self-checking bench for credit_out_scheduler: directed scenarios plus random
// traffic compared against a behavioural credit/round-robin model.
module tb_credit_out_scheduler;

  localparam int NUM_REQ = 3;
  localparam int VC_W    = 1;
  localparam int DEPTH   = 4;
  localparam int NVC     = 2;
  localparam int CMAX    = DEPTH - 1;
  localparam int SEL_W   = 2;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NUM_REQ-1:0]      req;
  logic [NUM_REQ*VC_W-1:0] req_vc;
  logic [NUM_REQ-1:0]      gnt;
  logic                    cred_ret;
  logic [VC_W-1:0]         cred_ret_vc;
  logic                    out_valid;
  logic [SEL_W-1:0]        out_sel;
  logic [VC_W-1:0]         out_vc;
  logic [NVC-1:0]          cred_avail;
  logic                    cred_err;

  credit_out_scheduler #(
    .NUM_REQ(NUM_REQ), .VC_W(VC_W), .VC_FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_vc(req_vc), .gnt(gnt),
    .cred_ret(cred_ret), .cred_ret_vc(cred_ret_vc),
    .out_valid(out_valid), .out_sel(out_sel), .out_vc(out_vc),
    .cred_avail(cred_avail), .cred_err(cred_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: credit counts, next search start, sticky error, last grant.
  int mcred [NVC];
  int mptr;
  bit merr;
  bit mvalid;
  int msel;
  int mvc;

  logic [NUM_REQ-1:0] obs_gnt;
  logic [NUM_REQ-1:0] exp_gnt;

  function automatic void model_reset();
    for (int v = 0; v < NVC; v++) mcred[v] = CMAX;
    mptr = 0; merr = 0; mvalid = 0; msel = 0; mvc = 0;
  endfunction

  function automatic logic [NVC-1:0] model_avail();
    logic [NVC-1:0] r;
    for (int v = 0; v < NVC; v++) r[v] = (mcred[v] > 0);
    return r;
  endfunction

  // Entered and left at posedge+1: apply inputs, sample gnt, clock once, advance model.
  task automatic drive_cycle(input logic [NUM_REQ-1:0] r, input logic [NUM_REQ*VC_W-1:0] v,
                             input logic cr, input logic [VC_W-1:0] crv);
    int g;
    int gvc;
    req = r; req_vc = v; cred_ret = cr; cred_ret_vc = crv;
    #1;
    obs_gnt = gnt;
    g = -1;
    gvc = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int i;
      i = (mptr + k) % NUM_REQ;
      if (g < 0 && r[i] && mcred[int'(v[i*VC_W +: VC_W])] > 0) g = i;
    end
    exp_gnt = '0;
    if (g >= 0) begin
      exp_gnt[g] = 1'b1;
      gvc = int'(v[g*VC_W +: VC_W]);
    end
    @(posedge clk);
    if (g >= 0) begin
      mcred[gvc]--;
      mptr = (g + 1) % NUM_REQ;
      msel = g; mvc = gvc; mvalid = 1;
    end else begin
      mvalid = 0;
    end
    if (cr) begin
      if (mcred[int'(crv)] == CMAX) merr = 1;
      else mcred[int'(crv)]++;
    end
    #1;
  endtask

  task automatic do_reset();
    req = '0; req_vc = '0; cred_ret = 1'b0; cred_ret_vc = '0;
    rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    req = '0; req_vc = '0; cred_ret = 1'b0; cred_ret_vc = '0;
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    total++; if (gnt !== 3'b000) begin bad++; $display("FAIL reset_gnt: got %b expected 000", gnt); end
    total++; if (cred_avail !== 2'b11) begin bad++; $display("FAIL reset_avail: got %b expected 11", cred_avail); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    total++; if (cred_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b expected 0", cred_err); end
    total++; if (out_sel !== 2'd0 || out_vc !== 1'b0) begin bad++; $display("FAIL reset_sel_vc: got %0d/%0d expected 0/0", out_sel, out_vc); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0 || cred_avail !== 2'b11) begin bad++; $display("FAIL idle: got valid=%b avail=%b expected 0/11", out_valid, cred_avail); end
  endtask

  task automatic test_round_robin();
    for (int k = 0; k < 3; k++) begin
      drive_cycle(3'b111, 3'b000, 1'b0, 1'b0);
      total++; if (obs_gnt !== exp_gnt) begin bad++; $display("FAIL rr_gnt%0d: got %b expected %b", k, obs_gnt, exp_gnt); end
      total++; if (out_valid !== 1'b1 || int'(out_sel) != k) begin bad++; $display("FAIL rr_out%0d: got valid=%b sel=%0d expected 1/%0d", k, out_valid, out_sel, k); end
    end
    drive_cycle(3'b111, 3'b000, 1'b0, 1'b0);
    total++; if (obs_gnt !== 3'b000) begin bad++; $display("FAIL rr_exhausted: got %b expected 000", obs_gnt); end
    total++; if (cred_avail !== model_avail() || out_valid !== 1'b0) begin bad++; $display("FAIL rr_avail: got avail=%b valid=%b expected %b/0", cred_avail, out_valid, model_avail()); end
  endtask

  task automatic test_vc_block();
    drive_cycle(3'b011, 3'b010, 1'b0, 1'b0);
    total++; if (obs_gnt !== exp_gnt) begin bad++; $display("FAIL vc_block_gnt: got %b expected %b", obs_gnt, exp_gnt); end
    total++; if (out_vc !== 1'b1 || out_sel !== 2'd1) begin bad++; $display("FAIL vc_block_out: got vc=%0d sel=%0d expected 1/1", out_vc, out_sel); end
    // Credit returned this cycle must not yet make requester 0 eligible.
    drive_cycle(3'b011, 3'b010, 1'b1, 1'b0);
    total++; if (obs_gnt !== exp_gnt) begin bad++; $display("FAIL ret_same_cycle: got %b expected %b", obs_gnt, exp_gnt); end
    drive_cycle(3'b011, 3'b010, 1'b0, 1'b0);
    total++; if (obs_gnt !== exp_gnt || obs_gnt !== 3'b001) begin bad++; $display("FAIL ret_next_cycle: got %b expected %b", obs_gnt, exp_gnt); end
  endtask

  task automatic test_consume_return();
    drive_cycle(3'b000, 3'b000, 1'b1, 1'b0);
    total++; if (cred_avail !== model_avail()) begin bad++; $display("FAIL cr_refill: got %b expected %b", cred_avail, model_avail()); end
    drive_cycle(3'b001, 3'b000, 1'b1, 1'b0);
    total++; if (obs_gnt !== exp_gnt) begin bad++; $display("FAIL cr_gnt: got %b expected %b", obs_gnt, exp_gnt); end
    total++; if (out_valid !== 1'b1 || cred_avail !== model_avail()) begin bad++; $display("FAIL cr_net: got valid=%b avail=%b expected 1/%b", out_valid, cred_avail, model_avail()); end
    drive_cycle(3'b001, 3'b000, 1'b0, 1'b0);
    total++; if (obs_gnt !== exp_gnt) begin bad++; $display("FAIL cr_one_left: got %b expected %b", obs_gnt, exp_gnt); end
    drive_cycle(3'b001, 3'b000, 1'b0, 1'b0);
    total++; if (obs_gnt !== exp_gnt) begin bad++; $display("FAIL cr_drained: got %b expected %b", obs_gnt, exp_gnt); end
  endtask

  task automatic test_overflow();
    do_reset();
    drive_cycle(3'b000, 3'b000, 1'b1, 1'b1);
    total++; if (cred_err !== merr) begin bad++; $display("FAIL ovf_err: got %b expected %b", cred_err, merr); end
    total++; if (cred_avail !== 2'b11) begin bad++; $display("FAIL ovf_avail: got %b expected 11", cred_avail); end
    // VC1 must still hold exactly CMAX credits: CMAX grants then none.
    for (int k = 0; k <= CMAX; k++) begin
      drive_cycle(3'b001, 3'b001, 1'b0, 1'b0);
      total++; if (obs_gnt !== exp_gnt) begin bad++; $display("FAIL ovf_drain%0d: got %b expected %b", k, obs_gnt, exp_gnt); end
    end
    total++; if (cred_err !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b expected 1", cred_err); end
  endtask

  task automatic test_random();
    logic [NUM_REQ-1:0]      r;
    logic [NUM_REQ*VC_W-1:0] v;
    logic                    cr;
    logic [VC_W-1:0]         crv;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      r   = NUM_REQ'($urandom_range(0, 7));
      v   = (NUM_REQ*VC_W)'($urandom);
      cr  = ($urandom_range(0, 2) == 0);
      crv = VC_W'($urandom);
      drive_cycle(r, v, cr, crv);
      total++; if (obs_gnt !== exp_gnt) begin bad++; $display("FAIL rnd_gnt@%0d: got %b expected %b", n, obs_gnt, exp_gnt); end
      total++; if (out_valid !== mvalid || int'(out_sel) != msel || int'(out_vc) != mvc) begin
        bad++; $display("FAIL rnd_out@%0d: got v=%b s=%0d c=%0d expected %b/%0d/%0d", n, out_valid, out_sel, out_vc, mvalid, msel, mvc);
      end
      total++; if (cred_avail !== model_avail() || cred_err !== merr) begin
        bad++; $display("FAIL rnd_cred@%0d: got avail=%b err=%b expected %b/%b", n, cred_avail, cred_err, model_avail(), merr);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 3; k++) drive_cycle(3'b111, 3'b000, 1'b0, 1'b0);
    req = 3'b111; req_vc = 3'b010;
    #1;
    total++; if (gnt !== 3'b010) begin bad++; $display("FAIL mid_pre: got %b expected 010", gnt); end
    rst = 1'b0;
    #1;
    total++; if (gnt !== 3'b000) begin bad++; $display("FAIL mid_gnt: got %b expected 000", gnt); end
    total++; if (cred_avail !== 2'b11 || out_valid !== 1'b0) begin bad++; $display("FAIL mid_state: got avail=%b valid=%b expected 11/0", cred_avail, out_valid); end
    @(posedge clk); #1;
    total++; if (gnt !== 3'b000) begin bad++; $display("FAIL mid_hold: got %b expected 000", gnt); end
    req = '0;
    model_reset();
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    drive_cycle(3'b111, 3'b000, 1'b0, 1'b0);
    total++; if (obs_gnt !== 3'b001) begin bad++; $display("FAIL mid_first: got %b expected 001", obs_gnt); end
    total++; if (cred_err !== 1'b0 || cred_avail !== 2'b11) begin bad++; $display("FAIL mid_after: got err=%b avail=%b expected 0/11", cred_err, cred_avail); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_vc_block();
    test_consume_return();
    test_overflow();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
